fifo_flex: RTL and testbench

Parametrised single-clock FIFO succeeding the fixed 4-bit × 8 FIFO: generic width and depth, occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It sits between the `ui_in` capture logic and the `uo_out` drive logic of the top-level Tiny Tapeout wrapper. It also serves as the standard buffering primitive for other blocks in the design.

---
 rtl/fifo_flex_pkg.sv | 14 +
 rtl/fifo_flex_ptr.sv | 52 +++++
 rtl/fifo_flex.sv | 54 +++++
 tb/tb_fifo_flex.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// fifo_flex_pkg: shared defaults, count-width helper and error-flag struct for fifo_flex
package fifo_flex_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AF = DEF_DEPTH - 2;
  localparam int DEF_AE = 2;
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_flex_ptr.sv
// fifo_flex_ptr: acceptance, pointer wrap, occupancy count, registered flags and sticky errors
module fifo_flex_ptr import fifo_flex_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic                     wr_acc,
  output logic                     rd_acc,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output fifo_err_t                err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = CNT_W(DEPTH);
  logic [CW-1:0] cnt_nxt;
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign cnt_nxt = count + CW'(wr_acc) - CW'(rd_acc);
  // Flags are registered from the next count so they line up with count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
      err <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      count <= cnt_nxt;
      full <= cnt_nxt == CW'(DEPTH);
      empty <= cnt_nxt == '0;
      almost_full <= int'(cnt_nxt) >= AF_LEVEL;
      almost_empty <= int'(cnt_nxt) <= AE_LEVEL;
      err.overflow <= (wr_en & full & ~rd_acc) | (err.overflow & ~clr_err);
      err.underflow <= (rd_en & empty) | (err.underflow & ~clr_err);
    end
  end
endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO; define FIFO_FLEX_FWFT_EN for first-word fall-through
module fifo_flex import fifo_flex_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   rd_en,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       rdata,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  fifo_err_t err;
  fifo_flex_ptr #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)) u_ptr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .clr_err(clr_err),
    .wr_acc(wr_acc), .rd_acc(rd_acc), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .err(err)
  );
  assign overflow = err.overflow;
  assign underflow = err.underflow;
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wdata;
  end
`ifdef FIFO_FLEX_FWFT_EN
  assign rdata = mem[rd_ptr];
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rdata <= mem[rd_ptr];
    end
  end
`endif
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: directed self-checking bench for fifo_flex (WIDTH=4, DEPTH=8, AF=6, AE=2)
module tb_fifo_flex;
  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [3:0] wdata = '0, rdata;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  int errs = 0, checks = 0;
  logic [3:0] q [$];
  logic [3:0] exp_d, d;
  fifo_flex #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .clr_err(clr_err),
    .rdata(rdata), .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step;
    step;
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rd_valid, 0);
    rst_n = 1'b1;
`ifdef FIFO_FLEX_FWFT_EN
    wr_en = 1'b1;
    wdata = 4'hA;
    step;
    wr_en = 1'b0;
    chk("fwft_rdata", rdata, 4'hA);
    chk("fwft_rvalid", rd_valid, 1);
    chk("fwft_count", count, 1);
    rd_en = 1'b1;
    step;
    rd_en = 1'b0;
    chk("fwft_empty", empty, 1);
    chk("fwft_rvalid0", rd_valid, 0);
`else
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wdata = 4'(i);
      step;
      chk("fill_count", count, i);
      chk("fill_af", almost_full, int'(i >= 6));
      chk("fill_full", full, int'(i == 8));
      chk("fill_ae", almost_empty, int'(i <= 2));
      chk("fill_empty", empty, 0);
    end
    wdata = 4'hF;
    step;
    wr_en = 1'b0;
    chk("ovf_count", count, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_full", full, 1);
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step;
      chk("drain_rvalid", rd_valid, 1);
      chk("drain_rdata", rdata, i);
      chk("drain_count", count, 8 - i);
    end
    chk("drain_empty", empty, 1);
    step;
    rd_en = 1'b0;
    chk("udf_flag", underflow, 1);
    chk("udf_empty", empty, 1);
    chk("udf_rvalid", rd_valid, 0);
    chk("udf_rdata_hold", rdata, 8);
    chk("udf_ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_udf", underflow, 0);
    // Preload three words, then stream 20 concurrent read/write cycles.
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 4'(12 + i);
      q.push_back(wdata);
      step;
    end
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 4'($urandom_range(0, 15));
      wdata = d;
      exp_d = q.pop_front();
      q.push_back(d);
      step;
      chk("wrap_count", count, 3);
      chk("wrap_rdata", rdata, exp_d);
      chk("wrap_rvalid", rd_valid, 1);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_d = q.pop_front();
      step;
      chk("wrap_drain", rdata, exp_d);
    end
    rd_en = 1'b0;
    chk("wrap_empty", empty, 1);
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wdata = 4'(i);
      q.push_back(wdata);
      step;
    end
    chk("refill_full", full, 1);
    rd_en = 1'b1;
    wdata = 4'h9;
    exp_d = q.pop_front();
    q.push_back(wdata);
    step;
    wr_en = 1'b0;
    chk("fullrw_count", count, 8);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_rdata", rdata, exp_d);
    chk("fullrw_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      exp_d = q.pop_front();
      step;
      chk("fullrw_drain", rdata, exp_d);
    end
    chk("fullrw_empty", empty, 1);
    wr_en = 1'b1;
    wdata = 4'h5;
    step;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("emptyrw_count", count, 1);
    chk("emptyrw_udf", underflow, 1);
    chk("emptyrw_rvalid", rd_valid, 0);
    chk("emptyrw_empty", empty, 0);
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr2_udf", underflow, 0);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_rdata", rdata, 0);
    rd_en = 1'b1;
    step;
    rd_en = 1'b0;
    chk("midrst_udf", underflow, 1);
    chk("midrst_rvalid", rd_valid, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
